// File: rtl/lo_nco_pkg.sv
// Shared types and constants for the quadrature LO NCO.
// Holds the quarter-wave table generator used to build the ROM.
package heai_lo_pkg;

  localparam int LO_LUT_ADDR_W = 8;
  localparam int LO_LUT_DEPTH  = 1 << LO_LUT_ADDR_W;
  localparam int LO_IDX_W      = LO_LUT_ADDR_W + 2;
  localparam int LO_MAG_W      = 7;
  localparam int LO_AMP        = 127;

  typedef logic signed [7:0]         lo_sample_t;
  typedef logic [1:0]                lo_quadrant_t;
  typedef logic [LO_LUT_ADDR_W-1:0]  lo_addr_t;
  typedef logic [LO_MAG_W-1:0]       lo_mag_t;

  // pi in Q30
  localparam longint LO_PI_Q = 64'sd3373259426;

  // round(127*sin(2*pi*(k+0.5)/1024)), Taylor series in Q30
  function automatic lo_mag_t lo_lut_val(input int k);
    longint theta;
    longint term;
    longint s;
    longint amp;
    theta = (longint'(2 * k + 1) * LO_PI_Q) >>> LO_IDX_W;
    term  = theta;
    s     = theta;
    for (int n = 1; n <= 8; n++) begin
      term = (term * theta) >>> 30;
      term = (term * theta) >>> 30;
      term = -term / longint'((2 * n) * (2 * n + 1));
      s    = s + term;
    end
    amp = (longint'(LO_AMP) * s + (longint'(1) <<< 29)) >>> 30;
    return lo_mag_t'(amp);
  endfunction

endpackage

// File: rtl/lo_nco_if.sv
// Control/sample bundle between the NCO and its user.
// master: drives tuning/strobes, reads I/Q; slave: the NCO.
interface lo_nco_if #(
  parameter int PHASE_W = 24,
  parameter int OUT_W   = 8
) ();

  logic [PHASE_W-1:0]      freq_word;
  logic                    freq_load;
  logic                    phase_clear;
  logic signed [OUT_W-1:0] lo_i;
  logic signed [OUT_W-1:0] lo_q;
  logic                    lo_valid;

  modport master (
    output freq_word, freq_load, phase_clear,
    input  lo_i, lo_q, lo_valid
  );

  modport slave (
    input  freq_word, freq_load, phase_clear,
    output lo_i, lo_q, lo_valid
  );

endinterface

// File: rtl/lo_nco_quarter_rom.sv
// Registered 256x7 quarter-sine table with two read ports.
// Ports: clk, rst, sin_addr/cos_addr in, sin_mag/cos_mag out.
module lo_quarter_rom
  import heai_lo_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  lo_addr_t sin_addr,
  input  lo_addr_t cos_addr,
  output lo_mag_t  sin_mag,
  output lo_mag_t  cos_mag
);

  lo_mag_t rom [LO_LUT_DEPTH];

  for (genvar k = 0; k < LO_LUT_DEPTH; k++) begin : g_rom
    localparam lo_mag_t VAL = lo_lut_val(k);
    assign rom[k] = VAL;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sin_mag <= '0;
      cos_mag <= '0;
    end else begin
      sin_mag <= rom[sin_addr];
      cos_mag <= rom[cos_addr];
    end
  end

endmodule

// File: rtl/lo_nco.sv
// Quadrature NCO: phase accumulator + quarter-wave ROM, 3-cycle latency.
// Ports: crystal (clock), rst (async high), bus (lo_nco_if slave).
module lo_nco
  import heai_lo_pkg::*;
#(
  parameter int PHASE_W = 24,
  parameter int OUT_W   = 8
) (
  input  logic  crystal,
  input  logic  rst,
  lo_nco_if.slave bus
);

  // S0: frequency and accumulator
  logic [PHASE_W-1:0] freq_reg;
  logic [PHASE_W-1:0] acc;

  always_ff @(posedge crystal or posedge rst) begin
    if (rst) begin
      freq_reg <= '0;
      acc      <= '0;
    end else begin
      if (bus.freq_load)
        freq_reg <= bus.freq_word;
      // add uses the pre-load frequency
      acc <= bus.phase_clear ? '0 : acc + freq_reg;
    end
  end

  // S1: quadrant decode; odd quadrants read the table mirrored
  logic [LO_IDX_W-1:0] idx;
  lo_quadrant_t        q_sin;
  lo_quadrant_t        q_cos;
  lo_addr_t            a;

  assign idx   = acc[PHASE_W-1 -: LO_IDX_W];
  assign q_sin = idx[LO_IDX_W-1 -: 2];
  assign a     = idx[LO_LUT_ADDR_W-1:0];
  assign q_cos = q_sin + 2'd1;

  lo_addr_t s1_sin_addr;
  lo_addr_t s1_cos_addr;
  logic     s1_sin_neg;
  logic     s1_cos_neg;

  always_ff @(posedge crystal or posedge rst) begin
    if (rst) begin
      s1_sin_addr <= '0;
      s1_cos_addr <= '0;
      s1_sin_neg  <= 1'b0;
      s1_cos_neg  <= 1'b0;
    end else begin
      s1_sin_addr <= q_sin[0] ? ~a : a;
      s1_cos_addr <= q_cos[0] ? ~a : a;
      s1_sin_neg  <= q_sin[1];
      s1_cos_neg  <= q_cos[1];
    end
  end

  // S2: table read, signs follow alongside
  lo_mag_t s2_sin_mag;
  lo_mag_t s2_cos_mag;
  logic    s2_sin_neg;
  logic    s2_cos_neg;

  lo_quarter_rom u_rom (
    .clk      (crystal),
    .rst      (rst),
    .sin_addr (s1_sin_addr),
    .cos_addr (s1_cos_addr),
    .sin_mag  (s2_sin_mag),
    .cos_mag  (s2_cos_mag)
  );

  always_ff @(posedge crystal or posedge rst) begin
    if (rst) begin
      s2_sin_neg <= 1'b0;
      s2_cos_neg <= 1'b0;
    end else begin
      s2_sin_neg <= s1_sin_neg;
      s2_cos_neg <= s1_cos_neg;
    end
  end

  // S3: sign application and output registers
  function automatic logic signed [OUT_W-1:0] apply_sign(
    input lo_mag_t m,
    input logic    neg
  );
    logic signed [OUT_W-1:0] v;
    v = signed'((OUT_W)'(m));
    return neg ? -v : v;
  endfunction

  logic signed [OUT_W-1:0] lo_i_r;
  logic signed [OUT_W-1:0] lo_q_r;
  logic [2:0]              vld;

  always_ff @(posedge crystal or posedge rst) begin
    if (rst) begin
      lo_i_r <= '0;
      lo_q_r <= '0;
      vld    <= '0;
    end else begin
      lo_i_r <= apply_sign(s2_cos_mag, s2_cos_neg);
      lo_q_r <= apply_sign(s2_sin_mag, s2_sin_neg);
      vld    <= {vld[1:0], 1'b1};
    end
  end

  assign bus.lo_i     = lo_i_r;
  assign bus.lo_q     = lo_q_r;
  assign bus.lo_valid = vld[2];

endmodule

// File: tb/tb_lo_nco.sv
// Directed self-checking bench for lo_nco.
// Drives/samples on the falling edge of crystal.
module tb_lo_nco;

  logic crystal;
  logic rst;
  int   n_chk;
  int   n_fail;

  lo_nco_if #(.PHASE_W(24), .OUT_W(8)) bus ();

  lo_nco #(.PHASE_W(24), .OUT_W(8)) dut (
    .crystal (crystal),
    .rst     (rst),
    .bus     (bus)
  );

  initial crystal = 1'b0;
  always #5 crystal = ~crystal;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic expect_lo(input string tag, input int ei, input int eq);
    check({tag, "_i"}, int'(bus.lo_i), ei);
    check({tag, "_q"}, int'(bus.lo_q), eq);
  endtask

  task automatic cyc(input logic fl, input logic [23:0] fw, input logic pc);
    bus.freq_load   = fl;
    bus.freq_word   = fw;
    bus.phase_clear = pc;
    @(negedge crystal);
    bus.freq_load   = 1'b0;
    bus.phase_clear = 1'b0;
  endtask

  task automatic release_check(input string tag);
    rst = 1'b0;
    @(negedge crystal);
    check({tag, "_vld_e1"}, int'(bus.lo_valid), 0);
    @(negedge crystal);
    check({tag, "_vld_e2"}, int'(bus.lo_valid), 0);
    @(negedge crystal);
    check({tag, "_vld_e3"}, int'(bus.lo_valid), 1);
    expect_lo({tag, "_first"}, 127, 0);
  endtask

  function automatic int mdl_sin(input int idx);
    real ph;
    ph = 2.0 * 3.14159265358979 * (real'(idx) + 0.5) / 1024.0;
    return int'(127.0 * $sin(ph));
  endfunction

  function automatic int mdl_cos(input int idx);
    real ph;
    ph = 2.0 * 3.14159265358979 * (real'(idx) + 0.5) / 1024.0;
    return int'(127.0 * $cos(ph));
  endfunction

  int qt_i [4] = '{127, 0, -127, 0};
  int qt_q [4] = '{0, 127, 0, -127};
  int ne_i [8] = '{127, 90, 0, -90, -127, -90, 0, 90};
  int ne_q [8] = '{0, -90, -127, -90, 0, 90, 127, 90};

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    bus.freq_word   = '0;
    bus.freq_load   = 1'b0;
    bus.phase_clear = 1'b0;
    repeat (2) @(negedge crystal);
    expect_lo("rst0", 0, 0);
    check("rst0_vld", int'(bus.lo_valid), 0);
    release_check("rel0");

    // quarter-rate tone
    cyc(1'b1, 24'h400000, 1'b1);
    repeat (2) @(negedge crystal);
    for (int k = 0; k < 8; k++) begin
      @(negedge crystal);
      expect_lo($sformatf("quarter%0d", k), qt_i[k % 4], qt_q[k % 4]);
    end

    // asynchronous reset mid-run
    #2 rst = 1'b1;
    #1;
    expect_lo("rst1", 0, 0);
    check("rst1_vld", int'(bus.lo_valid), 0);
    @(negedge crystal);
    expect_lo("rst1_hold", 0, 0);
    release_check("rel1");

    // zero frequency
    cyc(1'b1, 24'h000000, 1'b1);
    repeat (2) @(negedge crystal);
    for (int k = 0; k < 6; k++) begin
      @(negedge crystal);
      expect_lo($sformatf("zero%0d", k), 127, 0);
    end

    // -1 step wraps below zero
    cyc(1'b1, 24'hFFFFFF, 1'b1);
    repeat (2) @(negedge crystal);
    for (int k = 0; k < 6; k++) begin
      int a;
      a = (-k) & 24'hFFFFFF;
      @(negedge crystal);
      expect_lo($sformatf("wrap%0d", k), mdl_cos(a >> 14), mdl_sin(a >> 14));
    end

    // -1/8 turn step: Q is the mirror of the +1/8 tone
    cyc(1'b1, 24'hE00000, 1'b1);
    repeat (2) @(negedge crystal);
    for (int k = 0; k < 8; k++) begin
      @(negedge crystal);
      expect_lo($sformatf("neg8th%0d", k), ne_i[k], ne_q[k]);
    end

    // load without clear takes effect one add later
    cyc(1'b1, 24'h400000, 1'b1);
    cyc(1'b1, 24'h200000, 1'b0);
    @(negedge crystal);
    @(negedge crystal);
    expect_lo("ldtime0", 127, 0);
    @(negedge crystal);
    expect_lo("ldtime1", 0, 127);
    @(negedge crystal);
    expect_lo("ldtime2", -90, 90);

    // simultaneous load and clear while running
    cyc(1'b1, 24'h400000, 1'b1);
    cyc(1'b0, 24'h000000, 1'b0);
    cyc(1'b0, 24'h000000, 1'b0);
    cyc(1'b1, 24'h200000, 1'b1);
    repeat (2) @(negedge crystal);
    @(negedge crystal);
    expect_lo("simul0", 127, 0);
    @(negedge crystal);
    expect_lo("simul1", 90, 90);
    @(negedge crystal);
    expect_lo("simul2", 0, 127);

    // full-period sweep against the ideal formula
    begin
      int bad_val;
      int bad_128;
      int bad_mag;
      int bad_vld;
      bad_val = 0;
      bad_128 = 0;
      bad_mag = 0;
      bad_vld = 0;
      cyc(1'b1, 24'h001000, 1'b1);
      repeat (2) @(negedge crystal);
      for (int n = 0; n < 4096; n++) begin
        int idx;
        int gi;
        int gq;
        int di;
        int dq;
        int m;
        @(negedge crystal);
        idx = (n >> 2) & 1023;
        gi  = int'(bus.lo_i);
        gq  = int'(bus.lo_q);
        di  = gi - mdl_cos(idx);
        dq  = gq - mdl_sin(idx);
        if (di > 1 || di < -1 || dq > 1 || dq < -1) bad_val++;
        if (gi == -128 || gq == -128) bad_128++;
        m = gi * gi + gq * gq;
        if (m > 16129 + 260 || m < 16129 - 260) bad_mag++;
        if (bus.lo_valid !== 1'b1) bad_vld++;
      end
      check("sweep_val", bad_val, 0);
      check("sweep_m128", bad_128, 0);
      check("sweep_mag", bad_mag, 0);
      check("sweep_vld", bad_vld, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
